// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with elaboration-time frame format, per-frame
// runtime divisor, valid/ready input, line-break generator and frame-done pulse.
module uart_tx_cfg #(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1,
   parameter int DIV_WIDTH = 16,
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD_RATE = 9600
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DIV_WIDTH-1:0] baud_div,
   input  logic                 s_valid,
   input  logic [DATA_BITS-1:0] s_data,
   output logic                 s_ready,
   input  logic                 tx_break,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done
);
   if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 || STOP_BITS < 1 ||
       STOP_BITS > 2 || DIV_WIDTH < 2 || CLK_FREQ / BAUD_RATE < 2) begin : g_bad_cfg
      $error("uart_tx_cfg: illegal configuration");
   end
   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;
   state_t               state_q, state_d;
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d, div_q, div_d;
   logic [3:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] sh_q, sh_d;
   logic                 par_q, par_d, tx_q, tx_d, busy_q, busy_d, done_q, done_d;
   logic                 last;
   assign s_ready = state_q == IDLE && !tx_break && !rst;
   assign last    = cnt_q == div_q - DIV_WIDTH'(1);
   assign tx      = tx_q;
   assign tx_busy = busy_q;
   assign tx_done = done_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         div_q   <= '0;
         sh_q    <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         div_q   <= div_d;
         sh_q    <= sh_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end
   // bit_q indexes data bits in DATA and counts stop bits in STOP
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + DIV_WIDTH'(1);
      bit_d   = bit_q;
      div_d   = div_q;
      sh_d    = sh_q;
      par_d   = par_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            if (tx_break) state_d = BRK;
            else if (s_valid && s_ready) begin
               state_d = START;
               sh_d    = s_data;
               div_d   = baud_div < DIV_WIDTH'(2) ? DIV_WIDTH'(2) : baud_div;
               par_d   = (^s_data) ^ (PARITY == 2);
            end
         end
         START: if (last) begin
            state_d = DATA;
            cnt_d   = '0;
            bit_d   = '0;
         end
         DATA: if (last) begin
            cnt_d = '0;
            sh_d  = sh_q >> 1;
            bit_d = bit_q == 4'(DATA_BITS - 1) ? 4'd0 : bit_q + 4'd1;
            if (bit_q == 4'(DATA_BITS - 1)) state_d = PARITY != 0 ? PAR : STOP;
         end
         PAR: if (last) begin
            state_d = STOP;
            cnt_d   = '0;
            bit_d   = '0;
         end
         STOP: if (last) begin
            cnt_d = '0;
            bit_d = bit_q + 4'd1;
            if (bit_q == 4'(STOP_BITS - 1)) state_d = IDLE;
         end
         BRK: begin
            cnt_d = '0;
            if (!tx_break) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   // outputs are registered from the next state so tx falls right after accept
   always_comb begin
      tx_d   = state_d == START || state_d == BRK ? 1'b0 :
               state_d == DATA ? sh_d[0] : state_d == PAR ? par_d : 1'b1;
      busy_d = state_d != IDLE;
      done_d = state_d == STOP && bit_d == 4'(STOP_BITS - 1) && cnt_d == div_d - DIV_WIDTH'(1);
   end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: four configurations of uart_tx_cfg driven in parallel and
// checked against a per-cycle frame model derived from the frame format.
module tb_uart_tx_cfg;
   logic        clk = 1'b0;
   logic        rst, s_valid, tx_break;
   logic [7:0]  s_data;
   logic [15:0] baud_div;
   logic        tx_w [4];
   logic        busy_w [4];
   logic        done_w [4];
   logic        rdy_w [4];
   int          checks = 0;
   int          failures = 0;
   always #5 clk = ~clk;
   uart_tx_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (.clk(clk), .rst(rst), .baud_div(baud_div),
      .s_valid(s_valid), .s_data(s_data), .s_ready(rdy_w[0]), .tx_break(tx_break), .tx(tx_w[0]),
      .tx_busy(busy_w[0]), .tx_done(done_w[0]));
   uart_tx_cfg #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (.clk(clk), .rst(rst), .baud_div(baud_div),
      .s_valid(s_valid), .s_data(s_data), .s_ready(rdy_w[1]), .tx_break(tx_break), .tx(tx_w[1]),
      .tx_busy(busy_w[1]), .tx_done(done_w[1]));
   uart_tx_cfg #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u2 (.clk(clk), .rst(rst), .baud_div(baud_div),
      .s_valid(s_valid), .s_data(s_data), .s_ready(rdy_w[2]), .tx_break(tx_break), .tx(tx_w[2]),
      .tx_busy(busy_w[2]), .tx_done(done_w[2]));
   uart_tx_cfg #(.DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u3 (.clk(clk), .rst(rst), .baud_div(baud_div),
      .s_valid(s_valid), .s_data(s_data[4:0]), .s_ready(rdy_w[3]), .tx_break(tx_break), .tx(tx_w[3]),
      .tx_busy(busy_w[3]), .tx_done(done_w[3]));
   function automatic int db(int i);
      return i == 3 ? 5 : 8;
   endfunction
   function automatic int pm(int i);
      return i == 1 ? 1 : i == 2 ? 2 : 0;
   endfunction
   function automatic int sb(int i);
      return i == 3 ? 2 : 1;
   endfunction
   function automatic int flen(int i, int d);
      return d * (1 + db(i) + (pm(i) != 0 ? 1 : 0) + sb(i));
   endfunction
   // expected line level k cycles after the accept edge (k = 1 is the first start cycle)
   function automatic logic exp_tx(int i, logic [7:0] data, int d, int k);
      int   b;
      logic p;
      b = (k - 1) / d;
      if (b == 0) return 1'b0;
      b--;
      if (b < db(i)) return data[3'(b)];
      b -= db(i);
      if (pm(i) != 0 && b == 0) begin
         p = pm(i) == 2;
         for (int j = 0; j < db(i); j++) p ^= data[3'(j)];
         return p;
      end
      return 1'b1;
   endfunction
   function automatic int st(int i);
      return {rdy_w[i], tx_w[i], busy_w[i], done_w[i]};
   endfunction
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", name, act, exp);
      end
   endtask
   task automatic wait_idle();
      int n = 0;
      while (!(rdy_w[0] && rdy_w[1] && rdy_w[2] && rdy_w[3]) && n < 3000) begin
         step();
         n++;
      end
      if (n >= 3000) begin
         checks++;
         failures++;
         $display("FAIL wait_idle timeout got=busy want=idle");
      end
   endtask
   task automatic run_frame(input int i, input logic [7:0] data, input int bd, input int nbd,
                            input int brk_at, output int done_at, output int terr, output int par_obs);
      int d, len;
      wait_idle();
      d = bd < 2 ? 2 : bd;
      len = flen(i, d);
      baud_div = 16'(bd);
      s_data = data;
      s_valid = 1'b1;
      done_at = 0;
      terr = 0;
      par_obs = -1;
      for (int k = 1; k <= len; k++) begin
         step();
         s_valid = 1'b0;
         s_data = 8'($urandom);
         if (k == 8 && nbd != 0) baud_div = 16'(nbd);
         if (k == brk_at) tx_break = 1'b1;
         if (tx_w[i] !== exp_tx(i, data, d, k) || busy_w[i] !== 1'b1) terr++;
         if (done_w[i]) begin
            if (done_at == 0) done_at = k;
            else terr++;
         end
         if (pm(i) != 0 && k == d * (1 + db(i)) + 1) par_obs = int'(tx_w[i]);
      end
   endtask
   typedef struct packed {
      int         i;
      logic [7:0] data;
      int         bd;
      int         nbd;
      int         len;
      int         par;
   } vec_t;
   vec_t tbl [9];
   initial begin
      int done_at, terr, par_obs, errs, dones, i, bd;
      logic [7:0] data;
      logic ex;
      tbl[0] = '{0, 8'hA5, 4, 0, 40, -1};
      tbl[1] = '{1, 8'h07, 4, 0, 44, 1};
      tbl[2] = '{2, 8'h07, 4, 0, 44, 0};
      tbl[3] = '{1, 8'h00, 4, 0, 44, 0};
      tbl[4] = '{3, 8'h1F, 3, 0, 24, -1};
      tbl[5] = '{0, 8'h3C, 1, 0, 20, -1};
      tbl[6] = '{0, 8'h81, 0, 0, 20, -1};
      tbl[7] = '{0, 8'hC3, 4, 8, 40, -1};
      tbl[8] = '{2, 8'hFF, 2, 0, 22, 1};
      rst = 1'b1;
      s_valid = 1'b0;
      s_data = 8'h00;
      tx_break = 1'b0;
      baud_div = 16'd4;
      repeat (3) step();
      for (int j = 0; j < 4; j++) chk("reset_state", st(j), 4'b0100);
      rst = 1'b0;
      #1;
      chk("reset_ready", int'(rdy_w[0]), 1);
      for (int v = 0; v < 9; v++) begin
         run_frame(tbl[v].i, tbl[v].data, tbl[v].bd, tbl[v].nbd, 0, done_at, terr, par_obs);
         chk($sformatf("vec%0d_len", v), done_at, tbl[v].len);
         chk($sformatf("vec%0d_txerr", v), terr, 0);
         if (tbl[v].par >= 0) chk($sformatf("vec%0d_par", v), par_obs, tbl[v].par);
         step();
         chk($sformatf("vec%0d_idle", v), st(tbl[v].i), 4'b1100);
      end
      // back-to-back frames with s_valid held
      wait_idle();
      baud_div = 16'd4;
      s_data = 8'h55;
      s_valid = 1'b1;
      errs = 0;
      dones = 0;
      for (int k = 1; k <= 86; k++) begin
         step();
         if (k == 1) s_data = 8'hAA;
         if (k == 42) s_valid = 1'b0;
         ex = k <= 40 ? exp_tx(0, 8'h55, 4, k) : k == 41 ? 1'b1 : k <= 81 ? exp_tx(0, 8'hAA, 4, k - 41) : 1'b1;
         if (tx_w[0] !== ex) errs++;
         if (done_w[0]) begin
            dones++;
            if (k != 40 && k != 81) errs++;
         end
      end
      chk("b2b_txerr", errs, 0);
      chk("b2b_dones", dones, 2);
      // reset during DATA
      wait_idle();
      s_data = 8'hF0;
      s_valid = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         step();
         s_valid = 1'b0;
      end
      chk("rst_pre", {tx_w[0], busy_w[0]}, 2'b01);
      rst = 1'b1;
      #1;
      chk("rst_ready", int'(rdy_w[0]), 0);
      step();
      rst = 1'b0;
      chk("rst_abort", st(0), 4'b0100);
      errs = 0;
      for (int k = 0; k < 45; k++) begin
         step();
         if (done_w[0] || !tx_w[0] || busy_w[0]) errs++;
      end
      chk("rst_quiet", errs, 0);
      // break in IDLE with s_valid also asserted
      wait_idle();
      tx_break = 1'b1;
      s_valid = 1'b1;
      s_data = 8'h00;
      #1;
      chk("brk_ready0", int'(rdy_w[0]), 0);
      errs = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (st(0) != 4'b0010) errs++;
      end
      chk("brk_hold", errs, 0);
      tx_break = 1'b0;
      s_valid = 1'b0;
      step();
      chk("brk_release", st(0), 4'b1100);
      step();
      chk("brk_no_accept", st(0), 4'b1100);
      // break requested mid-frame
      run_frame(0, 8'h96, 4, 0, 5, done_at, terr, par_obs);
      chk("brkmid_len", done_at, 40);
      chk("brkmid_txerr", terr, 0);
      step();
      chk("brkmid_idle", st(0), 4'b0100);
      step();
      chk("brkmid_break", st(0), 4'b0010);
      tx_break = 1'b0;
      step();
      chk("brkmid_release", st(0), 4'b1100);
      // randomized frames
      for (int r = 0; r < 24; r++) begin
         i = int'($urandom_range(0, 3));
         data = 8'($urandom);
         bd = int'($urandom_range(0, 7));
         run_frame(i, data, bd, 0, 0, done_at, terr, par_obs);
         chk($sformatf("rnd%0d_len", r), done_at, flen(i, bd < 2 ? 2 : bd));
         chk($sformatf("rnd%0d_txerr", r), terr, 0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter that replaces the fixed 8N1 transmitter in the serial I/O path.
- Frame format is set at elaboration: data bits, parity mode and stop-bit count.
- Bit period comes from a runtime divisor, captured per frame.
- Data enters through a valid/ready handshake.
- Adds a line-break generator and a frame-done pulse for upstream sequencers and the interrupt logic.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, sent LSB first
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame, legal 1 or 2
DIV_WIDTH, 16, width of baud_div
CLK_FREQ, 50000000, system clock in Hz (documentation and default-divisor derivation only)
BAUD_RATE, 9600, nominal baud; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE is the recommended baud_div value

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
baud_div  in  DIV_WIDTH  clocks per bit; sampled on the accept cycle
s_valid  in  1  upstream data valid
s_data  in  DATA_BITS  frame payload
s_ready  out  1  transmitter can accept a frame
tx_break  in  1  request to drive a break (line low)
tx  out  1  serial line, idle high
tx_busy  out  1  frame in progress
tx_done  out  1  one-cycle pulse at end of frame

Behaviour:
- All logic on posedge clk. Reset is synchronous, active-high, overrides everything and aborts any frame immediately.
- Reset values: tx=1, tx_busy=0, tx_done=0, state=IDLE, bit counter=0, clock counter=0.
- tx, tx_busy and tx_done are registered.
- s_ready is combinational: s_ready = (state==IDLE) && !tx_break && !rst.
- States: IDLE, START, DATA, PARITY (only when PARITY!=0), STOP, BREAK.
- IDLE:
  - tx=1, tx_busy=0.
  - If tx_break=1: go to BREAK.
  - Else on s_valid && s_ready (accept): latch s_data into the shift register, latch D = max(baud_div, 2), compute the parity bit, set tx_busy=1, go to START.
- Divisor rules:
  - D is held for the whole frame; baud_div changes mid-frame have no effect.
  - baud_div of 0 or 1 is clamped to 2.
- Bit timing:
  - Every bit state lasts exactly D cycles.
  - The clock counter runs 0..D-1 and resets to 0 on each state/bit change.
- Latency: tx falls on the first cycle after the accept cycle.
- START: tx=0 for D cycles, then go to DATA with bit index 0.
- DATA:
  - tx = shift_reg[bit index], D cycles per bit, LSB first.
  - After bit DATA_BITS-1, go to PARITY if enabled, else STOP.
- PARITY:
  - Even: tx = XOR of the latched data bits.
  - Odd: tx = inverse of the even value.
  - Lasts D cycles, then go to STOP.
- STOP:
  - tx=1 for STOP_BITS*D cycles.
  - tx_done=1 during the final cycle of the last stop bit.
  - Next cycle: IDLE, with tx_busy=0 and tx_done=0.
- Frame length, from first low cycle to the first IDLE cycle: D*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles.
- Back-to-back: if s_valid is held, the accept occurs in the first IDLE cycle. This gives exactly one extra tx=1 cycle between the last stop bit and the next start bit.
- BREAK:
  - tx=0, tx_busy=1, s_ready=0 for as long as tx_break=1.
  - When tx_break falls, go to IDLE; tx=1 from the next cycle. No tx_done pulse.
- tx_break during a frame is ignored until IDLE; the frame completes unaltered.
- s_valid && tx_break in the same IDLE cycle: break wins, no accept.
- s_data and s_valid changes outside the accept cycle have no effect.
- Reset mid-frame: on the cycle after rst is sampled high, tx=1 and tx_busy=0, no tx_done pulse, and the partial frame is lost.

Test Plan:
- DATA_BITS=8, PARITY=0, STOP_BITS=1, baud_div=4, send 0xA5:
  - tx = 0x4, then 1,0,1,0,0,1,0,1 each x4, then 1x4.
  - 40 cycles total; tx_done high on cycle 40 only; s_ready high again on cycle 41.
- PARITY=1, send 0x07: parity bit = 1. PARITY=2, send 0x07: parity bit = 0. PARITY=1, send 0x00: parity bit = 0.
- STOP_BITS=2, DATA_BITS=5, baud_div=3, send 0x1F: start 3 cycles, five ones x3, stop high 6 cycles; frame = 24 cycles.
- baud_div=1: each bit lasts 2 cycles. Changing baud_div from 4 to 8 mid-frame leaves the current frame at 4 cycles/bit.
- s_valid held high with 0x55 then 0xAA: exactly one idle-high cycle between the two frames; both frames bit-exact; two tx_done pulses.
- Edge cases, each checked in sequence:
  - Assert rst in the DATA state: tx=1, tx_busy=0 the next cycle, no tx_done.
  - tx_break=1 in IDLE for 20 cycles: tx=0 and s_ready=0 throughout; tx=1 the cycle after release.
  - tx_break raised mid-frame: the frame completes before break begins.
